// File: rtl/seq_muldiv_pkg.sv
// Shared opcode encodings and FSM state type for the sequential multiply/divide unit.
package seq_muldiv_pkg;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_QUO = 2'b01;
   localparam logic [1:0] OP_REM = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_div_op(input logic [1:0] op);
      return (op == OP_QUO) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring-divide step,
// both built around a single W+1 bit adder.
module muldiv_step #(
   parameter int W = 32
) (
   input  logic         is_div,
   input  logic [W-1:0] hi,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] opnd,
   output logic [W-1:0] hi_nxt,
   output logic [W-1:0] lo_nxt
);

   logic [W:0] shifted;
   logic [W:0] op_a;
   logic [W:0] op_b;
   logic [W:0] sum;

   // Divide subtracts via inverted operand plus carry-in; a set sum[W] means the trial went negative.
   always_comb begin
      shifted = {hi, lo[W-1]};
      if (is_div) begin
         op_a = shifted;
         op_b = ~{1'b0, opnd};
      end else begin
         op_a = {1'b0, hi};
         op_b = lo[0] ? {1'b0, opnd} : '0;
      end
      sum = op_a + op_b + {{W{1'b0}}, is_div};
      if (is_div) begin
         hi_nxt = sum[W] ? shifted[W-1:0] : sum[W-1:0];
         lo_nxt = {lo[W-2:0], ~sum[W]};
      end else begin
         hi_nxt = sum[W:1];
         lo_nxt = {sum[0], lo[W-1:1]};
      end
   end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative unsigned multiply/quotient/remainder unit, one result per start/ready handshake.
// Define SEQ_MULDIV_HI_EN to add the out_hi port (upper product / companion division result).
module seq_muldiv #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         s1,
   input  logic         s0,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         ready,
   output logic         done,
   output logic [W-1:0] out,
   output logic         err
`ifdef SEQ_MULDIV_HI_EN
   ,
   output logic [W-1:0] out_hi
`endif
);

   import seq_muldiv_pkg::*;

   localparam int CW = $clog2(W);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [1:0]     op;
   logic [1:0]     op_in;
   logic           fast;
   logic           fast_in;
   logic           accept;
   logic           last;
   logic [W-1:0]   hi, lo, opnd;
   logic [W-1:0]   hi_nxt, lo_nxt;
   logic [W-1:0]   res_out;
   logic           res_err;
`ifdef SEQ_MULDIV_HI_EN
   logic [W-1:0]   res_hi;
`endif

   assign op_in   = {s1, s0};
   assign fast_in = (op_in == OP_RSV) || (is_div_op(op_in) && (y == '0));

   muldiv_step #(.W(W)) u_step (
      .is_div (is_div_op(op)),
      .hi     (hi),
      .lo     (lo),
      .opnd   (opnd),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Zero-divisor and reserved ops spend a single CALC cycle with count 0 and take the result from here.
   always_comb begin
      res_out = '0;
      res_err = 1'b0;
`ifdef SEQ_MULDIV_HI_EN
      res_hi  = '0;
`endif
      if (fast) begin
         res_err = 1'b1;
         if (op == OP_QUO)      res_out = '1;
         else if (op == OP_REM) res_out = lo;
      end else begin
         case (op)
            OP_MUL: begin
               res_out = lo_nxt;
`ifdef SEQ_MULDIV_HI_EN
               res_hi  = hi_nxt;
`else
               res_err = |hi_nxt;
`endif
            end
            OP_QUO: begin
               res_out = lo_nxt;
`ifdef SEQ_MULDIV_HI_EN
               res_hi  = hi_nxt;
`endif
            end
            OP_REM: begin
               res_out = hi_nxt;
`ifdef SEQ_MULDIV_HI_EN
               res_hi  = lo_nxt;
`endif
            end
            default: res_err = 1'b1;
         endcase
      end
   end

   // Multiply keeps the multiplier in lo; divide keeps the dividend there so quotient bits shift in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         op     <= OP_MUL;
         fast   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         opnd   <= '0;
         out    <= '0;
         err    <= 1'b0;
`ifdef SEQ_MULDIV_HI_EN
         out_hi <= '0;
`endif
      end else if (accept) begin
         op   <= op_in;
         fast <= fast_in;
         cnt  <= fast_in ? '0 : CW'(W - 1);
         hi   <= '0;
         lo   <= is_div_op(op_in) ? x : y;
         opnd <= is_div_op(op_in) ? y : x;
      end else if (state == CALC) begin
         hi <= hi_nxt;
         lo <= lo_nxt;
         if (cnt != '0) cnt <= cnt - CW'(1);
         if (last) begin
            out    <= res_out;
            err    <= res_err;
`ifdef SEQ_MULDIV_HI_EN
            out_hi <= res_hi;
`endif
         end
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed self-checking bench for seq_muldiv; out_hi checks follow SEQ_MULDIV_HI_EN.
module tb_seq_muldiv;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         s1 = 1'b0;
   logic         s0 = 1'b0;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         ready;
   logic         done;
   logic [W-1:0] out;
   logic         err;
`ifdef SEQ_MULDIV_HI_EN
   logic [W-1:0] out_hi;
`endif

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_muldiv #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .s1     (s1),
      .s0     (s0),
      .x      (x),
      .y      (y),
      .ready  (ready),
      .done   (done),
      .out    (out),
      .err    (err)
`ifdef SEQ_MULDIV_HI_EN
      ,
      .out_hi (out_hi)
`endif
   );

   // Issues one operation, scrambles the inputs after acceptance, and returns edges until done.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        output int lat);
      int n;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      x = a;
      y = b;
      {s1, s0} = op;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      x = ~a;
      y = ~b;
      {s1, s0} = ~op;
      lat = 0;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (out !== '0) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 0", out); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (out_hi !== '0) begin n_fail++; $display("[TB] FAIL reset_out_hi: got %h expected 0", out_hi); end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul;
      int lat;
      do_op(32'd73, 32'd10, 2'b00, lat);
      n_checks++; if (lat !== W) begin n_fail++; $display("[TB] FAIL mul_latency: got %0d expected %0d", lat, W); end
      n_checks++; if (out !== 32'd730) begin n_fail++; $display("[TB] FAIL mul_73x10: got %0d expected 730", out); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL mul_73x10_err: got %b expected 0", err); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (out_hi !== '0) begin n_fail++; $display("[TB] FAIL mul_73x10_hi: got %h expected 0", out_hi); end
`endif
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ready_during_done: got %b expected 0", ready); end
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ready_return: got %b expected 1", ready); end
      do_op(32'd730, 32'd10, 2'b00, lat);
      n_checks++; if (out !== 32'd7300) begin n_fail++; $display("[TB] FAIL mul_730x10: got %0d expected 7300", out); end
   endtask

   task automatic test_divide;
      int lat;
      do_op(32'd73, 32'd10, 2'b01, lat);
      n_checks++; if (lat !== W) begin n_fail++; $display("[TB] FAIL quo_latency: got %0d expected %0d", lat, W); end
      n_checks++; if (out !== 32'd7) begin n_fail++; $display("[TB] FAIL quo_73_10: got %0d expected 7", out); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL quo_73_10_err: got %b expected 0", err); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (out_hi !== 32'd3) begin n_fail++; $display("[TB] FAIL quo_73_10_hi: got %0d expected 3", out_hi); end
`endif
      do_op(32'd73, 32'd10, 2'b10, lat);
      n_checks++; if (out !== 32'd3) begin n_fail++; $display("[TB] FAIL rem_73_10: got %0d expected 3", out); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (out_hi !== 32'd7) begin n_fail++; $display("[TB] FAIL rem_73_10_hi: got %0d expected 7", out_hi); end
`endif
      do_op(32'd730, 32'd10, 2'b01, lat);
      n_checks++; if (out !== 32'd73) begin n_fail++; $display("[TB] FAIL quo_730_10: got %0d expected 73", out); end
      do_op(32'd730, 32'd10, 2'b10, lat);
      n_checks++; if (out !== 32'd0) begin n_fail++; $display("[TB] FAIL rem_730_10: got %0d expected 0", out); end
      n_checks++; if (lat !== W) begin n_fail++; $display("[TB] FAIL rem_latency: got %0d expected %0d", lat, W); end
   endtask

   task automatic test_div_zero;
      int lat;
      do_op(32'd5, 32'd0, 2'b01, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL divzero_latency: got %0d expected 1", lat); end
      n_checks++; if (out !== 32'hFFFF_FFFF) begin n_fail++; $display("[TB] FAIL divzero_quo: got %h expected ffffffff", out); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL divzero_quo_err: got %b expected 1", err); end
      do_op(32'd5, 32'd0, 2'b10, lat);
      n_checks++; if (out !== 32'd5) begin n_fail++; $display("[TB] FAIL divzero_rem: got %0d expected 5", out); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL divzero_rem_err: got %b expected 1", err); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (out_hi !== '0) begin n_fail++; $display("[TB] FAIL divzero_hi: got %h expected 0", out_hi); end
`endif
      @(posedge clk);
      #1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL divzero_ready: got %b expected 1", ready); end
   endtask

   task automatic test_overflow_reserved;
      int lat;
      do_op(32'h0001_0000, 32'h0001_0000, 2'b00, lat);
      n_checks++; if (out !== '0) begin n_fail++; $display("[TB] FAIL ovf_out: got %h expected 0", out); end
`ifdef SEQ_MULDIV_HI_EN
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_err: got %b expected 0", err); end
      n_checks++; if (out_hi !== 32'd1) begin n_fail++; $display("[TB] FAIL ovf_hi: got %h expected 1", out_hi); end
`else
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_err: got %b expected 1", err); end
`endif
      do_op(32'd9, 32'd3, 2'b11, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL rsv_latency: got %0d expected 1", lat); end
      n_checks++; if (out !== '0) begin n_fail++; $display("[TB] FAIL rsv_out: got %h expected 0", out); end
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL rsv_err: got %b expected 1", err); end
   endtask

   task automatic test_ignore_start;
      int lat;
      int n;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      x = 32'd73; y = 32'd10; {s1, s0} = 2'b00; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_ready: got %b expected 0", ready); end
      lat = 0;
      repeat (5) begin @(posedge clk); #1; lat++; end
      @(negedge clk);
      x = 32'd5; y = 32'd3; {s1, s0} = 2'b01; start = 1'b1;
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
      n_checks++; if (lat !== W) begin n_fail++; $display("[TB] FAIL ignore_latency: got %0d expected %0d", lat, W); end
      n_checks++; if (out !== 32'd730) begin n_fail++; $display("[TB] FAIL ignore_out: got %0d expected 730", out); end
   endtask

   task automatic test_reset_mid;
      int n;
      int ndone;
      n = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      x = 32'd123; y = 32'd7; {s1, s0} = 2'b01; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_ready: got %b expected 1", ready); end
      n_checks++; if (out !== '0) begin n_fail++; $display("[TB] FAIL midreset_out: got %h expected 0", out); end
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (W + 5) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) ndone++;
      end
      n_checks++; if (ndone !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", ndone); end
      n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_idle: got %b expected 1", ready); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_divide();
      test_div_zero();
      test_overflow_reserved();
      test_ignore_start();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
